// File: rtl/game_pkg.sv
// Shared definitions for the breakout game sequencer.
//   - HUD-visible game_state codes (S_IDLE/S_PLAY/S_WIN/S_END)
//   - brick count, internal FSM encoding, popcount helper for scoring
package game_pkg;

  localparam int N_BRICKS = 50;
  localparam int HIT_W    = $clog2(N_BRICKS + 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_WIN  = 2'b10;
  localparam logic [1:0] S_END  = 2'b11;

  // The low two bits of every state equal its game_state code, so the
  // output is a plain slice of the state register. SERVE shows as IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = {1'b0, S_IDLE},
    ST_PLAY  = {1'b0, S_PLAY},
    ST_WIN   = {1'b0, S_WIN},
    ST_END   = {1'b0, S_END},
    ST_SERVE = {1'b1, S_IDLE}
  } fsm_e;

  function automatic logic [HIT_W-1:0] popcount(input logic [N_BRICKS-1:0] v);
    logic [HIT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_BRICKS; i++) c = c + HIT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bus between the game sequencer and the ball/racket datapath, brick
// renderer and HUD.
//   master (sequencer): drives game_state, game_reset, brick_alive, lives,
//                       score; receives lose_sig, brick_collision.
//   slave  (datapath/HUD side): the mirror image.
interface game_if #(parameter int SCORE_W = 16);
  logic                         lose_sig;
  logic [game_pkg::N_BRICKS-1:0] brick_collision;
  logic [1:0]                   game_state;
  logic                         game_reset;
  logic [game_pkg::N_BRICKS-1:0] brick_alive;
  logic [2:0]                   lives;
  logic [SCORE_W-1:0]           score;

  modport master (
    input  lose_sig, brick_collision,
    output game_state, game_reset, brick_alive, lives, score
  );

  modport slave (
    output lose_sig, brick_collision,
    input  game_state, game_reset, brick_alive, lives, score
  );
endinterface

// File: rtl/game_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debouncer, press pulse.
//   clk, rst : clock and asynchronous active-high reset
//   btn_n_i  : raw active-low button, asynchronous to clk
//   press_o  : one-cycle pulse when the accepted level goes released->pressed
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;   // accepted level, 1 = released
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ, expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign differ = (sync_q[1] != level_q);
  assign expire = differ && (cnt_q == CNT_LAST);

  // Any sample agreeing with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (expire)      level_d = sync_q[1];
    else if (differ) cnt_d   = cnt_q + 1'b1;
  end

  // Pulse is raised in the cycle the new pressed level is being accepted.
  assign press_o = expire & ~sync_q[1];

endmodule

// File: rtl/game_ctrl.sv
// Breakout game sequencer.
//   vga_clk, sys_rst : clock and asynchronous active-high reset
//   start_n          : raw active-low start button
//   bus (master)     : lose_sig/brick_collision in; game_state, game_reset,
//                      brick_alive, lives, score out (all registered)
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SERVE_DELAY     = 25000000,
  parameter int SCORE_W         = 16
) (
  input  logic vga_clk,
  input  logic sys_rst,
  input  logic start_n,
  game_if.master bus
);
  localparam int SDW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [SDW-1:0] SERVE_LAST = SDW'(SERVE_DELAY - 1);
  localparam logic [2:0]     LIVES_INIT = 3'(LIVES);
  localparam int             SUM_W      = SCORE_W + 1;

  fsm_e                  state_q, state_d;
  logic [N_BRICKS-1:0]   alive_q, alive_d;
  logic [2:0]            lives_q, lives_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [SDW-1:0]        serve_q, serve_d;
  logic                  greset_q, greset_d;
  logic                  lose_q;

  logic                  start_evt, lose_evt;
  logic [N_BRICKS-1:0]   hit, remain;
  logic [SUM_W-1:0]      score_sum;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk     (vga_clk),
    .rst     (sys_rst),
    .btn_n_i (start_n),
    .press_o (start_evt)
  );

  assign lose_evt  = bus.lose_sig & ~lose_q;
  // Dead bricks are masked out so a repeated hit never scores twice.
  assign hit       = bus.brick_collision & alive_q;
  assign remain    = alive_q & ~hit;
  assign score_sum = {1'b0, score_q} + SUM_W'(popcount(hit));

  // State register and datapath registers
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      alive_q  <= '1;
      lives_q  <= LIVES_INIT;
      score_q  <= '0;
      serve_q  <= '0;
      greset_q <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      alive_q  <= alive_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      serve_q  <= serve_d;
      greset_q <= greset_d;
      lose_q   <= bus.lose_sig;
    end
  end

  // Next-state logic; clearing the last brick beats a simultaneous loss.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_evt) state_d = ST_PLAY;
      ST_PLAY: begin
        if (remain == '0)  state_d = ST_WIN;
        else if (lose_evt) state_d = (lives_q == 3'd1) ? ST_END : ST_SERVE;
      end
      ST_SERVE: if (serve_q == SERVE_LAST) state_d = ST_PLAY;
      ST_WIN, ST_END: if (start_evt) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    alive_d  = alive_q;
    lives_d  = lives_q;
    score_d  = score_q;
    serve_d  = '0;           // outside SERVE the counter idles at 0
    greset_d = 1'b0;
    unique case (state_q)
      ST_PLAY: begin
        alive_d = remain;
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (remain != '0 && lose_evt) begin
          if (lives_q == 3'd1) begin
            lives_d = 3'd0;
          end else begin
            lives_d  = lives_q - 3'd1;
            greset_d = 1'b1;
          end
        end
      end
      ST_SERVE: serve_d = serve_q + 1'b1;
      ST_WIN, ST_END: begin
        if (start_evt) begin
          alive_d  = '1;
          lives_d  = LIVES_INIT;
          score_d  = '0;
          greset_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.game_state  = state_q[1:0];
  assign bus.game_reset  = greset_q;
  assign bus.brick_alive = alive_q;
  assign bus.lives       = lives_q;
  assign bus.score       = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl with DEBOUNCE_CYCLES=4, SERVE_DELAY=8.
module tb_game_ctrl;
  localparam int DEB   = 4;
  localparam int SERVE = 8;

  localparam int M_IDLE = 0, M_PLAY = 1, M_SERVE = 2, M_WIN = 3, M_END = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_n = 1'b1;

  game_if #(.SCORE_W(16)) bus ();

  game_ctrl #(
    .LIVES(3), .DEBOUNCE_CYCLES(DEB), .SERVE_DELAY(SERVE), .SCORE_W(16)
  ) dut (
    .vga_clk (clk),
    .sys_rst (rst),
    .start_n (start_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [49:0] all_ones;
  logic [49:0] b49;

  // Behavioural reference model
  int          m_mode;
  logic [49:0] m_alive;
  int          m_lives;
  int          m_score;
  bit          m_gr;
  bit          m_lose_prev;
  int          m_serve_edges;

  typedef struct {
    logic [49:0] bc;
    logic        lose;
    logic [49:0] alive;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [1:0]  gs;
    logic        gr;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_gs(input int mode);
    case (mode)
      M_PLAY:  return 2'b01;
      M_WIN:   return 2'b10;
      M_END:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_alive = all_ones; m_lives = 3; m_score = 0;
    m_gr = 0; m_lose_prev = 0; m_serve_edges = 0;
  endtask

  // One clock edge of the game rules, from the inputs currently driven.
  task automatic model_step(input bit evt);
    logic [49:0] h;
    m_gr = 0;
    case (m_mode)
      M_IDLE: if (evt) m_mode = M_PLAY;
      M_PLAY: begin
        h = bus.brick_collision & m_alive;
        m_alive = m_alive & ~h;
        m_score = m_score + $countones(h);
        if (m_score > 65535) m_score = 65535;
        if (m_alive == 0) m_mode = M_WIN;
        else if (bus.lose_sig && !m_lose_prev) begin
          if (m_lives == 1) begin
            m_lives = 0; m_mode = M_END;
          end else begin
            m_lives--; m_gr = 1; m_mode = M_SERVE; m_serve_edges = 0;
          end
        end
      end
      M_SERVE: begin
        m_serve_edges++;
        if (m_serve_edges == SERVE) m_mode = M_PLAY;
      end
      default: if (evt) begin
        m_alive = all_ones; m_lives = 3; m_score = 0; m_gr = 1; m_mode = M_IDLE;
      end
    endcase
    m_lose_prev = bus.lose_sig;
  endtask

  task automatic compare_all();
    chk("game_state",  64'(bus.game_state),  64'(exp_gs(m_mode)));
    chk("game_reset",  64'(bus.game_reset),  64'(m_gr));
    chk("brick_alive", 64'(bus.brick_alive), 64'(m_alive));
    chk("lives",       64'(bus.lives),       64'(m_lives));
    chk("score",       64'(bus.score),       64'(m_score));
  endtask

  task automatic cyc(input bit evt);
    model_step(evt);
    @(posedge clk); #1;
    compare_all();
  endtask

  // Full press and release; the debounced press is consumed on edge DEB+2.
  task automatic press();
    bus.brick_collision = '0; bus.lose_sig = 1'b0;
    start_n = 1'b0;
    for (int k = 1; k <= DEB + 4; k++) cyc(k == DEB + 2);
    start_n = 1'b1;
    for (int k = 1; k <= DEB + 4; k++) cyc(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    all_ones = '1;
    b49 = 50'd1 << 49;
    bus.brick_collision = '0;
    bus.lose_sig = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b0);

    // 3-cycle glitch must not start the game
    start_n = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b0);
    start_n = 1'b1;
    for (int k = 0; k < DEB + 4; k++) cyc(1'b0);
    $display("glitch: game_state=%0d", bus.game_state);

    // Real press -> PLAY on edge 6 after the fall
    press();
    chk("t1_state", 64'(bus.game_state), 64'(2'b01));
    chk("t1_lives", 64'(bus.lives), 64'd3);
    $display("press: game_state=%0d lives=%0d", bus.game_state, bus.lives);

    // Table: hits, repeat hit on dead brick, lose rise, ignored hit in SERVE
    vecs[0] = '{50'h5, 1'b0, all_ones & ~50'h5, 16'd2, 3'd3, 2'b01, 1'b0};
    vecs[1] = '{50'h1, 1'b0, all_ones & ~50'h5, 16'd2, 3'd3, 2'b01, 1'b0};
    vecs[2] = '{50'h0, 1'b1, all_ones & ~50'h5, 16'd2, 3'd2, 2'b00, 1'b1};
    vecs[3] = '{50'h8, 1'b1, all_ones & ~50'h5, 16'd2, 3'd2, 2'b00, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.brick_collision = vecs[i].bc;
      bus.lose_sig = vecs[i].lose;
      cyc(1'b0);
      chk("vec_alive", 64'(bus.brick_alive), 64'(vecs[i].alive));
      chk("vec_score", 64'(bus.score), 64'(vecs[i].score));
      chk("vec_lives", 64'(bus.lives), 64'(vecs[i].lives));
      chk("vec_state", 64'(bus.game_state), 64'(vecs[i].gs));
      chk("vec_reset", 64'(bus.game_reset), 64'(vecs[i].gr));
      $display("vec %0d: alive=%0h score=%0d lives=%0d state=%0d reset=%0d",
               i, bus.brick_alive, bus.score, bus.lives, bus.game_state, bus.game_reset);
    end

    // lose_sig held high: SERVE for 8 cycles then PLAY, no second decrement
    bus.brick_collision = '0;
    for (int k = 0; k < 18; k++) cyc(1'b0);
    chk("t3_state", 64'(bus.game_state), 64'(2'b01));
    chk("t3_lives", 64'(bus.lives), 64'd2);
    bus.lose_sig = 1'b0;
    cyc(1'b0);

    // Lose remaining lives -> END, then restart
    guard = 0;
    while (m_mode != M_END && guard < 200) begin
      bus.lose_sig = (m_mode == M_PLAY && !m_lose_prev);
      cyc(1'b0);
      guard++;
    end
    chk("t4_reach_end", 64'(guard < 200), 64'd1);
    chk("t4_state", 64'(bus.game_state), 64'(2'b11));
    chk("t4_lives", 64'(bus.lives), 64'd0);
    press();
    chk("t4_idle", 64'(bus.game_state), 64'(2'b00));
    chk("t4_mask", 64'(bus.brick_alive), 64'(all_ones));
    chk("t4_score", 64'(bus.score), 64'd0);
    $display("restart: state=%0d lives=%0d score=%0d", bus.game_state, bus.lives, bus.score);
    press();

    // Last brick and lose rise together -> WIN
    bus.brick_collision = all_ones & ~b49;
    cyc(1'b0);
    bus.brick_collision = b49;
    bus.lose_sig = 1'b1;
    cyc(1'b0);
    chk("t5_state", 64'(bus.game_state), 64'(2'b10));
    chk("t5_lives", 64'(bus.lives), 64'd3);
    chk("t5_score", 64'(bus.score), 64'd50);
    $display("win: state=%0d lives=%0d score=%0d", bus.game_state, bus.lives, bus.score);
    bus.brick_collision = '0; bus.lose_sig = 1'b0;
    cyc(1'b0);

    // Randomised play against the model
    for (int it = 0; it < 300; it++) begin
      if (m_mode == M_IDLE || m_mode == M_WIN || m_mode == M_END) begin
        press();
      end else begin
        bus.brick_collision = {$urandom, $urandom} & {$urandom, $urandom} &
                              {$urandom, $urandom} & {$urandom, $urandom};
        bus.lose_sig = ($urandom_range(0, 7) == 0);
        cyc(1'b0);
      end
    end
    $display("random: %0d checks so far", n_chk);

    // Asynchronous reset in the middle of SERVE
    bus.brick_collision = '0; bus.lose_sig = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) cyc(1'b0);
    press();
    bus.lose_sig = 1'b1;
    cyc(1'b0);
    bus.lose_sig = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("t6_pre_lives", 64'(bus.lives), 64'd2);
    #3 rst = 1'b1;
    #1;
    chk("t6_state", 64'(bus.game_state), 64'(2'b00));
    chk("t6_reset", 64'(bus.game_reset), 64'd0);
    chk("t6_alive", 64'(bus.brick_alive), 64'(all_ones));
    chk("t6_lives", 64'(bus.lives), 64'd3);
    chk("t6_score", 64'(bus.score), 64'd0);
    $display("async reset: state=%0d lives=%0d", bus.game_state, bus.lives);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) cyc(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
